// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key-event outputs of the keyboard decoder.
// The decoder sits on the slave side; a line driver/consumer uses master.
interface ps2_key_decoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_stb;
    logic        err;

    modport master (output ps2_clk, output ps2_data, input ps2_key, input key_stb, input err);
    modport slave  (input ps2_clk, input ps2_data, output ps2_key, output key_stb, output err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the lines, frames 11-bit
// packets, and turns scan-code bytes (with E0/F0/E1 prefixes) into key events.
module ps2_key_decoder #(
    parameter int unsigned FILT    = 4,
    parameter int unsigned TIMEOUT = 50000
) (
    input logic           clk_sys,
    input logic           reset,
    ps2_key_decoder_if.slave ps2
);
    localparam int unsigned FW = $clog2(FILT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    clk_sync, dat_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          ext, brk;
    logic [2:0]    skip;
    logic [10:0]   key_q;
    logic          stb_q, err_q;

    logic clk_s_c, bit_d_c, flip_c, bit_evt_c, timeout_c;
    logic frame_ok_c, frame_err_c;

    assign clk_s_c   = clk_sync[1];
    assign bit_d_c   = dat_sync[1];
    assign flip_c    = (clk_s_c != filt_clk) && (filt_cnt == FW'(FILT - 1));
    assign bit_evt_c = flip_c && filt_clk;
    assign timeout_c = (state != IDLE) && (to_cnt == TW'(TIMEOUT - 1));

    // Two-stage synchronizers; idle-high so release from reset is not an edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2.ps2_clk};
            dat_sync <= {dat_sync[0], ps2.ps2_data};
        end
    end

    // Clock filter: a new level is taken on the FILT-th consecutive differing sample
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s_c == filt_clk) begin
            filt_cnt <= '0;
        end else if (flip_c) begin
            filt_clk <= clk_s_c;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Frame sequencing; a bit event arriving on the timeout cycle still counts
    always_comb begin
        state_nxt   = state;
        frame_ok_c  = 1'b0;
        frame_err_c = 1'b0;
        if (bit_evt_c) begin
            case (state)
                IDLE:   if (!bit_d_c) state_nxt = DATA;
                DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (bit_d_c && (^{shift, par_bit})) frame_ok_c  = 1'b1;
                    else                                frame_err_c = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout_c) begin
            state_nxt   = IDLE;
            frame_err_c = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            to_cnt <= (state == IDLE || bit_evt_c) ? '0 : to_cnt + TW'(1);
            if (bit_evt_c) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {bit_d_c, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= bit_d_c;
                    default: ;
                endcase
            end
        end
    end

    // Prefix tracking and event generation from accepted bytes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            skip  <= '0;
            key_q <= '0;
            stb_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            err_q <= frame_err_c;
            if (frame_err_c) begin
                ext  <= 1'b0;
                brk  <= 1'b0;
                skip <= '0;
            end else if (frame_ok_c) begin
                if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                end else if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shift == 8'hE1) begin
                    skip <= 3'd7;
                end else begin
                    key_q <= {~key_q[10], ~brk, ext, shift};
                    stb_q <= 1'b1;
                    ext   <= 1'b0;
                    brk   <= 1'b0;
                end
            end
        end
    end

    assign ps2.ps2_key = key_q;
    assign ps2.key_stb = stb_q;
    assign ps2.err     = err_q;
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILT, default 4: consecutive identical synchronized samples required to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT, default 50000: clk_sys cycles without an accepted ps2_clk falling edge before an in-progress frame is abandoned.
REQ-003 clk_sys  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-007 ps2_key  output  11  event word {toggle, pressed, extended, code[7:0]}; bit 10 inverts on every new event.
REQ-008 key_stb  output  1  one-cycle pulse coincident with each ps2_key update.
REQ-009 err  output  1  one-cycle pulse on parity, start/stop framing error or timeout.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer.
REQ-011 Filtered clock SHALL change level only after FILT consecutive equal synchronized samples; the falling edge of the filtered clock is the bit-sample event.
REQ-012 Data SHALL be sampled from the synchronized ps2_data on the bit-sample event.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: sample 0 -> DATA with bit counter 0; sample 1 -> stay IDLE, no error.
REQ-015 DATA: shift sample into byte, LSB first; after 8th bit -> PARITY.
REQ-016 PARITY: capture bit -> STOP; parity is odd over the 8 data bits plus parity bit.
REQ-017 STOP: sample 1 and parity good -> byte accepted; otherwise err pulse, byte discarded; either way -> IDLE.
REQ-018 Timeout counter SHALL clear on every bit-sample event and in IDLE; reaching TIMEOUT outside IDLE -> IDLE, err pulse.
REQ-019 Accepted byte 0xE0 SHALL set ext flag; no event.
REQ-020 Accepted byte 0xF0 SHALL set brk flag; no event.
REQ-021 Accepted byte 0xE1 SHALL load a skip counter with 7; while nonzero, each accepted byte decrements it and is discarded with no event and no flag change.
REQ-022 Any other accepted byte SHALL produce an event: ps2_key <= {~ps2_key[10], ~brk, ext, byte}; ext and brk cleared.
REQ-023 Latency: ps2_key and key_stb SHALL update on the cycle after the STOP-bit sample event.
REQ-024 Any error (parity, framing, timeout) SHALL clear ext, brk and skip counter; ps2_key SHALL remain unchanged.
REQ-025 err and key_stb SHALL never assert in the same cycle.
REQ-026 Repeated prefixes (E0 E0, F0 F0) SHALL leave the flag set; no error.
REQ-027 Between events ps2_key SHALL hold its last value indefinitely.

Reset
REQ-028 On reset assertion, asynchronously: FSM IDLE, ps2_key = 0x000, key_stb = 0, err = 0, flags, counters, shift register and filters cleared, filtered clock = 1.
REQ-029 Reset mid-frame SHALL discard the partial frame with no event and no err pulse; the next complete frame after release SHALL decode normally.

Verification
REQ-030 From reset, frame 0x29 (parity 0) -> one key_stb, ps2_key = 0x629.
REQ-031 Then F0, 29 -> one key_stb only, after second byte; ps2_key = 0x029.
REQ-032 Then E0, 75 -> ps2_key = 0x775; then E0, F0, 75 -> ps2_key = 0x175.
REQ-033 Frame 0x29 with parity bit inverted -> one err pulse, no key_stb, ps2_key unchanged; following F0, 29 -> normal decode.
REQ-034 Start bit plus 4 data bits, then idle bus > TIMEOUT cycles -> err pulse at TIMEOUT, FSM IDLE; next frame 0x1C decodes with toggle flipped.
REQ-035 Glitches on ps2_clk of FILT-1 cycles -> no bit-sample event; sequence E1 14 77 E1 F0 14 F0 77 -> no key_stb, no err.
